mem_port_arbiter: RTL and testbench

//  Shares the single read/write port of the data memory between the pipeline memory stage (primary)
//  and a DMA/display engine (secondary). Pipeline has priority; a starvation counter forces DMA grants.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/arb_sat_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [1:0] {S_NORMAL, S_FORCE, S_LOCK} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_DMA} owner_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter. Clear wins over increment; clear with increment restarts at 1.
module arb_sat_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the pipeline memory stage (priority) and a DMA engine,
// with starvation-forced DMA grants and bounded DMA lock bursts.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_ready,
  output logic              pipe_rvalid,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        active_q, active_d;
  logic        gate;
  logic        pipe_grant, dma_grant;
  logic        wait_inc;
  logic [WAIT_W-1:0] wait_cnt;
  logic        wait_sat;
  logic [BEAT_W-1:0] beat_cnt;
  logic        beat_sat;

  // Outputs stay quiet during reset and for the first cycle after it.
  assign gate     = active_q & ~rst;
  assign active_d = 1'b1;

  assign wait_inc = gate & dma_valid & ~dma_grant;

  arb_sat_counter #(.W(WAIT_W), .LIMIT(MAX_WAIT)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (~wait_inc),
    .cnt (wait_cnt),
    .sat (wait_sat)
  );

  // Every DMA grant outside S_LOCK that carries dma_lock is beat 1 of a new burst.
  arb_sat_counter #(.W(BEAT_W), .LIMIT(MAX_BURST)) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dma_grant & dma_lock),
    .clr (state_q != S_LOCK),
    .cnt (beat_cnt),
    .sat (beat_sat)
  );

  always_comb begin
    pipe_grant = 1'b0;
    dma_grant  = 1'b0;
    state_d    = state_q;
    if (gate) begin
      unique case (state_q)
        S_NORMAL: begin
          if (pipe_valid)     pipe_grant = 1'b1;
          else if (dma_valid) dma_grant  = 1'b1;
          if (dma_grant && dma_lock) begin
            state_d = S_LOCK;
          end else if (dma_valid && !dma_grant &&
                       (wait_sat || (wait_cnt == WAIT_W'(MAX_WAIT - 1)))) begin
            state_d = S_FORCE;
          end
        end
        S_FORCE: begin
          dma_grant = dma_valid;
          state_d   = (dma_valid && dma_lock) ? S_LOCK : S_NORMAL;
        end
        S_LOCK: begin
          // The burst-limit exit cycle is itself the pipeline grant or idle cycle that re-arms locking.
          dma_grant  = dma_valid && dma_lock && (beat_cnt != BEAT_W'(MAX_BURST));
          pipe_grant = beat_sat && pipe_valid;
          state_d    = dma_grant ? S_LOCK : S_NORMAL;
        end
        default: state_d = S_NORMAL;
      endcase
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (pipe_grant && !pipe_we)     owner_d = OWN_PIPE;
    else if (dma_grant && !dma_we)  owner_d = OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NORMAL;
      owner_q  <= OWN_NONE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      active_q <= active_d;
    end
  end

  assign pipe_ready = pipe_grant;
  assign dma_ready  = dma_grant;
  assign stall      = gate & pipe_valid & ~pipe_grant;

  assign mem_we    = (pipe_grant & pipe_we) | (dma_grant & dma_we);
  assign mem_addr  = dma_grant ? dma_addr  : (gate ? pipe_addr  : '0);
  assign mem_wdata = dma_grant ? dma_wdata : (gate ? pipe_wdata : '0);

  // A response in flight when reset arrives is dropped.
  assign pipe_rvalid = ~rst & (owner_q == OWN_PIPE);
  assign dma_rvalid  = ~rst & (owner_q == OWN_DMA);
  assign pipe_rdata  = pipe_rvalid ? mem_rdata : '0;
  assign dma_rdata   = dma_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks plus a read-response scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pipe_valid = 1'b0, pipe_we = 1'b0;
  logic [AW-1:0] pipe_addr = '0;
  logic [DW-1:0] pipe_wdata = '0;
  logic          pipe_ready, pipe_rvalid;
  logic [DW-1:0] pipe_rdata;
  logic          dma_valid = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_ready, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_ready(pipe_ready), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
    .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {8'h5A, a[15:0]};
  endfunction

  // Synchronous write-first memory.
  logic [DW-1:0] mem_store [int];
  always @(posedge clk) begin
    if (mem_we) begin
      mem_rdata <= mem_wdata;
      mem_store[int'(mem_addr)] = mem_wdata;
    end else begin
      mem_rdata <= mem_store.exists(int'(mem_addr)) ? mem_store[int'(mem_addr)] : init_val(mem_addr);
    end
  end

  // Scoreboard: expected contents tracked from accepted requests; read responses due one cycle later.
  typedef struct { logic is_dma; logic [DW-1:0] data; int due; } exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] model_mem [int];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.is_dma && (dma_rvalid !== 1'b1 || dma_rdata !== e.data || pipe_rvalid !== 1'b0)) begin
          errors++;
          $display("FAIL sb_dma_resp cyc=%0d got rvalid=%b rdata=%h pipe_rvalid=%b exp rvalid=1 rdata=%h pipe_rvalid=0",
                   cyc, dma_rvalid, dma_rdata, pipe_rvalid, e.data);
        end else if (!e.is_dma && (pipe_rvalid !== 1'b1 || pipe_rdata !== e.data || dma_rvalid !== 1'b0)) begin
          errors++;
          $display("FAIL sb_pipe_resp cyc=%0d got rvalid=%b rdata=%h dma_rvalid=%b exp rvalid=1 rdata=%h dma_rvalid=0",
                   cyc, pipe_rvalid, pipe_rdata, dma_rvalid, e.data);
        end
      end else begin
        checks++;
        if (pipe_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL sb_spurious cyc=%0d got pipe_rvalid=%b dma_rvalid=%b exp 0 0", cyc, pipe_rvalid, dma_rvalid);
        end
      end
      checks++;
      if (pipe_ready === 1'b1 && dma_ready === 1'b1) begin
        errors++;
        $display("FAIL sb_one_grant cyc=%0d got both ready=1 exp at most one", cyc);
      end
      if (pipe_valid && pipe_ready === 1'b1) begin
        if (pipe_we) model_mem[int'(pipe_addr)] = pipe_wdata;
        else exp_q.push_back('{1'b0, model_rd(pipe_addr), cyc + 1});
      end
      if (dma_valid && dma_ready === 1'b1) begin
        if (dma_we) model_mem[int'(dma_addr)] = dma_wdata;
        else exp_q.push_back('{1'b1, model_rd(dma_addr), cyc + 1});
      end
    end
  end

  task automatic drop_all(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pipe_valid = 1'b0; dma_valid = 1'b0; dma_lock = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_addr = 20'h00055; pipe_wdata = 24'h000777;
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 20'h00066;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({pipe_ready, dma_ready, stall, mem_we, pipe_rvalid, dma_rvalid} !== 6'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b%b stall=%b we=%b rv=%b%b addr=%h exp all 0",
               pipe_ready, dma_ready, stall, mem_we, pipe_rvalid, dma_rvalid, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pipe_ready, dma_ready, stall, mem_we, pipe_rvalid, dma_rvalid} !== 6'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_first_cycle got rdy=%b%b stall=%b we=%b rv=%b%b addr=%h exp all 0",
               pipe_ready, dma_ready, stall, mem_we, pipe_rvalid, dma_rvalid, mem_addr);
    end
    @(posedge clk); #1;
    dma_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b1 || stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 20'h00055) begin
      errors++;
      $display("FAIL reset_release got rdy=%b stall=%b we=%b addr=%h exp 1 0 1 00055", pipe_ready, stall, mem_we, mem_addr);
    end
    drop_all(2);
  endtask

  task automatic test_pipe_only;
    @(posedge clk); #1;
    pipe_valid = 1'b1; pipe_we = 1'b1; pipe_addr = 20'h00010; pipe_wdata = 24'hABCDEF;
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b1 || stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 20'h00010 || mem_wdata !== 24'hABCDEF) begin
      errors++;
      $display("FAIL pipe_write got rdy=%b stall=%b we=%b addr=%h wdata=%h exp 1 0 1 00010 abcdef",
               pipe_ready, stall, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    pipe_we = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b1 || stall !== 1'b0 || mem_we !== 1'b0 || pipe_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL pipe_read got rdy=%b stall=%b we=%b rvalid=%b exp 1 0 0 0", pipe_ready, stall, mem_we, pipe_rvalid);
    end
    @(posedge clk); #1;
    pipe_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_rvalid !== 1'b1 || pipe_rdata !== 24'hABCDEF || dma_rdata !== '0) begin
      errors++;
      $display("FAIL pipe_readback got rvalid=%b rdata=%h dma_rdata=%h exp 1 abcdef 000000", pipe_rvalid, pipe_rdata, dma_rdata);
    end
    drop_all(2);
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    pipe_valid = 1'b1; pipe_we = 1'b0; pipe_addr = 20'h00020;
    dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 20'h00020; dma_wdata = 24'h123456; dma_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_ready !== 1'b1 || dma_ready !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL simul_first got pipe_rdy=%b dma_rdy=%b we=%b exp 1 0 0", pipe_ready, dma_ready, mem_we);
    end
    @(posedge clk); #1;
    pipe_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dma_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 24'h123456 ||
        pipe_rvalid !== 1'b1 || pipe_rdata !== init_val(20'h00020)) begin
      errors++;
      $display("FAIL simul_second got dma_rdy=%b we=%b wdata=%h prv=%b prd=%h exp 1 1 123456 1 %h",
               dma_ready, mem_we, mem_wdata, pipe_rvalid, pipe_rdata, init_val(20'h00020));
    end
    @(posedge clk); #1;
    dma_valid = 1'b0;
    pipe_valid = 1'b1;
    @(posedge clk); #1;
    pipe_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_rvalid !== 1'b1 || pipe_rdata !== 24'h123456) begin
      errors++;
      $display("FAIL simul_readback got rvalid=%b rdata=%h exp 1 123456", pipe_rvalid, pipe_rdata);
    end
    drop_all(2);
  endtask

  task automatic test_starvation;
    logic exp_dma;
    pipe_we = 1'b0; pipe_addr = 20'h00030;
    dma_we = 1'b0; dma_addr = 20'h00040; dma_lock = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      pipe_valid = 1'b1; dma_valid = 1'b1;
      @(negedge clk);
      exp_dma = (k % 5 == 0);
      checks++;
      if (dma_ready !== exp_dma || stall !== exp_dma || pipe_ready !== !exp_dma) begin
        errors++;
        $display("FAIL starve k=%0d got dma_rdy=%b stall=%b pipe_rdy=%b exp %b %b %b",
                 k, dma_ready, stall, pipe_ready, exp_dma, exp_dma, !exp_dma);
      end
    end
    drop_all(2);
  endtask

  task automatic test_lock_burst;
    int beats = 0;
    logic exp_rdy;
    dma_we = 1'b0; dma_lock = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(posedge clk); #1;
      dma_valid = 1'b1; dma_lock = 1'b1; dma_addr = 20'h00100 + AW'(beats);
      @(negedge clk);
      exp_rdy = (j != 8);
      checks++;
      if (dma_ready !== exp_rdy || pipe_ready !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL lock_beat j=%0d got dma_rdy=%b pipe_rdy=%b stall=%b exp %b 0 0", j, dma_ready, pipe_ready, stall, exp_rdy);
      end
      if (dma_ready === 1'b1) beats++;
    end
    checks++;
    if (beats != 16) begin
      errors++;
      $display("FAIL lock_total got beats=%0d exp 16", beats);
    end
    drop_all(3);
  endtask

  task automatic test_reset_mid_read;
    @(posedge clk); #1;
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 20'h00105; dma_lock = 1'b1;
    @(negedge clk);
    checks++;
    if (dma_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrd_grant got dma_rdy=%b exp 1", dma_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1; dma_valid = 1'b0; dma_lock = 1'b0;
    @(negedge clk);
    checks++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== '0) begin
      errors++;
      $display("FAIL midrd_discard got rvalid=%b rdata=%h exp 0 000000", dma_rvalid, dma_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_NORMAL || dut.wait_cnt !== '0 || dma_rvalid !== 1'b0 || pipe_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrd_after got state=%0d wait=%0d rv=%b%b exp 0 0 00",
               dut.state_q, dut.wait_cnt, pipe_rvalid, dma_rvalid);
    end
    drop_all(3);
  endtask

  task automatic test_idle;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      pipe_valid = 1'b0; dma_valid = 1'b0; dma_lock = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_we, pipe_ready, dma_ready, stall, pipe_rvalid, dma_rvalid} !== 6'b0) begin
        errors++;
        $display("FAIL idle k=%0d got we=%b rdy=%b%b stall=%b rv=%b%b exp all 0",
                 k, mem_we, pipe_ready, dma_ready, stall, pipe_rvalid, dma_rvalid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_simultaneous();
    test_starvation();
    test_lock_burst();
    test_reset_mid_read();
    test_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got pending=%0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
